// File: rtl/cpu_p_pkg.sv
// Shared state, opcode and shift encodings for the cpu_p multi-cycle core.
// Latency: n/a (declarations only).
// Backpressure: n/a; the core itself uses the s/load/w handshake.
package cpu_p_pkg;

    typedef enum logic [2:0] {
        S_WAIT      = 3'd0,
        S_DECODE    = 3'd1,
        S_GET_A     = 3'd2,
        S_GET_B     = 3'd3,
        S_EXEC      = 3'd4,
        S_WRITE     = 3'd5,
        S_WRITE_IMM = 3'd6
    } state_t;

    // Opcode is in[15:13] concatenated with the op field in[12:11].
    localparam logic [4:0] OP_MOV_IMM = 5'b110_10;
    localparam logic [4:0] OP_MOV_REG = 5'b110_00;
    localparam logic [4:0] OP_ADD     = 5'b101_00;
    localparam logic [4:0] OP_CMP     = 5'b101_01;
    localparam logic [4:0] OP_AND     = 5'b101_10;
    localparam logic [4:0] OP_MVN     = 5'b101_11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

endpackage

// File: rtl/regfile_p.sv
// 8-entry register file: one write port, one combinational read port.
// Latency: write lands on the clock edge, read is combinational (0 cycles).
// Backpressure: none; i_we is a single-cycle strobe.
// Ports: clk, i_reset (sync, active-high), i_we/i_waddr/i_wdata (write),
//        i_raddr -> o_rdata (read).
module regfile_p #(
    parameter int DATA_W     = 16,
    parameter int RESET_REGS = 1
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_we,
    input  logic [2:0]        i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [2:0]        i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_regs [8];

    // A reset edge always suppresses a pending write, even when the
    // contents themselves are not cleared.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            if (RESET_REGS != 0) begin
                for (int i = 0; i < 8; i++) begin
                    r_regs[i] <= '0;
                end
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_regs[i_raddr];

endmodule

// File: rtl/cpu_p.sv
// Multi-cycle RISC core: FSM controller, shifter, ALU, N/V/Z flags, 8 registers.
// Latency: MOV-imm 3, MOV-reg/MVN/CMP 5, ADD/AND 6, illegal 2 edges from s to w.
// Backpressure: s and load are honoured only while w=1 (WAIT); no queuing.
// Ports: clk, reset (sync, active-high), s (start), load (IR load), in (16-bit
//        instruction), out (result register C), N/V/Z flags, w (idle), illegal.
module cpu_p
    import cpu_p_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int RESET_REGS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic              load,
    input  logic [15:0]       in,
    output logic [DATA_W-1:0] out,
    output logic              N,
    output logic              V,
    output logic              Z,
    output logic              w,
    output logic              illegal
);

    state_t            r_state;
    state_t            w_next;
    logic [15:0]       r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_c;
    logic              r_n;
    logic              r_v;
    logic              r_z;
    logic              r_illegal;

    logic [4:0]        w_op;
    logic [2:0]        w_rn;
    logic [2:0]        w_rd;
    logic [2:0]        w_rm;
    logic [1:0]        w_sh;
    logic [DATA_W-1:0] w_imm_sext;

    logic [DATA_W-1:0] w_sh_b;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W-1:0] w_diff;
    logic [DATA_W-1:0] w_result;
    logic              w_ovf;
    logic              w_flag_upd;
    logic              w_legal;

    logic [2:0]        w_raddr;
    logic [DATA_W-1:0] w_rdata;
    logic              w_we;
    logic [2:0]        w_waddr;
    logic [DATA_W-1:0] w_wdata;

    assign w_op       = r_ir[15:11];
    assign w_rn       = r_ir[10:8];
    assign w_rd       = r_ir[7:5];
    assign w_sh       = r_ir[4:3];
    assign w_rm       = r_ir[2:0];
    assign w_imm_sext = DATA_W'($signed(r_ir[7:0]));

    assign w_legal = (w_op == OP_MOV_IMM) || (w_op == OP_MOV_REG) ||
                     (w_op == OP_ADD)     || (w_op == OP_CMP)     ||
                     (w_op == OP_AND)     || (w_op == OP_MVN);

    // ---------------- shifter and ALU ----------------
    always_comb begin
        w_sh_b = r_b;
        case (w_sh)
            SH_LSL:  w_sh_b = {r_b[DATA_W-2:0], 1'b0};
            SH_LSR:  w_sh_b = {1'b0, r_b[DATA_W-1:1]};
            SH_ASR:  w_sh_b = {r_b[DATA_W-1], r_b[DATA_W-1:1]};
            default: w_sh_b = r_b;
        endcase
    end

    assign w_sum  = r_a + w_sh_b;
    assign w_diff = r_a - w_sh_b;

    always_comb begin
        w_result   = w_sh_b;
        w_ovf      = 1'b0;
        w_flag_upd = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_result   = w_sum;
                w_ovf      = (r_a[DATA_W-1] == w_sh_b[DATA_W-1]) &&
                             (w_sum[DATA_W-1] != r_a[DATA_W-1]);
                w_flag_upd = 1'b1;
            end
            OP_CMP: begin
                w_result   = w_diff;
                w_ovf      = (r_a[DATA_W-1] != w_sh_b[DATA_W-1]) &&
                             (w_diff[DATA_W-1] != r_a[DATA_W-1]);
                w_flag_upd = 1'b1;
            end
            OP_AND: begin
                w_result   = r_a & w_sh_b;
                w_flag_upd = 1'b1;
            end
            OP_MVN: begin
                w_result   = ~w_sh_b;
                w_flag_upd = 1'b1;
            end
            default: begin
                w_result = w_sh_b;
            end
        endcase
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT: begin
                if (s) w_next = S_DECODE;
            end
            S_DECODE: begin
                case (w_op)
                    OP_MOV_IMM:                 w_next = S_WRITE_IMM;
                    OP_MOV_REG, OP_MVN:         w_next = S_GET_B;
                    OP_ADD, OP_CMP, OP_AND:     w_next = S_GET_A;
                    default:                    w_next = S_WAIT;
                endcase
            end
            S_GET_A:     w_next = S_GET_B;
            S_GET_B:     w_next = S_EXEC;
            S_EXEC:      w_next = (w_op == OP_CMP) ? S_WAIT : S_WRITE;
            S_WRITE:     w_next = S_WAIT;
            S_WRITE_IMM: w_next = S_WAIT;
            default:     w_next = S_WAIT;
        endcase
    end

    // ---------------- register file access ----------------
    // The single read port serves Rn in GET_A and Rm everywhere else.
    always_comb begin
        w_raddr = w_rm;
        w_we    = 1'b0;
        w_waddr = w_rd;
        w_wdata = r_c;
        if (r_state == S_GET_A) w_raddr = w_rn;
        if (r_state == S_WRITE) begin
            w_we = 1'b1;
        end else if (r_state == S_WRITE_IMM) begin
            w_we    = 1'b1;
            w_waddr = w_rn;
            w_wdata = w_imm_sext;
        end
    end

    regfile_p #(
        .DATA_W     (DATA_W),
        .RESET_REGS (RESET_REGS)
    ) u_regfile (
        .clk     (clk),
        .i_reset (reset),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // ---------------- sequential state ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_WAIT;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_n       <= 1'b0;
            r_v       <= 1'b0;
            r_z       <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            // IR is frozen outside WAIT so the running instruction cannot change.
            if (r_state == S_WAIT && load) r_ir <= in;
            if (r_state == S_DECODE) r_illegal <= ~w_legal;
            if (r_state == S_GET_A) r_a <= w_rdata;
            if (r_state == S_GET_B) r_b <= w_rdata;
            if (r_state == S_EXEC) begin
                r_c <= w_result;
                if (w_flag_upd) begin
                    r_n <= w_result[DATA_W-1];
                    r_v <= w_ovf;
                    r_z <= (w_result == '0);
                end
            end
        end
    end

    assign out     = r_c;
    assign N       = r_n;
    assign V       = r_v;
    assign Z       = r_z;
    assign w       = (r_state == S_WAIT);
    assign illegal = r_illegal;

endmodule

// File: tb/tb_cpu_p.sv
// Bench for cpu_p: a 16-bit (no register reset) and an 8-bit (register reset)
// instance run the same instruction stream against a behavioural model.
// Registers are observed by executing MOV Rx,Rx and reading out.
module tb_cpu_p;

    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic        load;
    logic [15:0] in;

    logic [15:0] out16;
    logic        n16, v16, z16, w16, ill16;
    logic [7:0]  out8;
    logic        n8, v8, z8, w8, ill8;

    always #5 clk = ~clk;

    cpu_p #(.DATA_W(16), .RESET_REGS(0)) u_dut16 (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
        .out(out16), .N(n16), .V(v16), .Z(z16), .w(w16), .illegal(ill16)
    );

    cpu_p #(.DATA_W(8), .RESET_REGS(1)) u_dut8 (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
        .out(out8), .N(n8), .V(v8), .Z(z8), .w(w8), .illegal(ill8)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural model (index 0: 16-bit, 1: 8-bit) ----------------
    logic [15:0] m_r [2][8];
    logic [15:0] m_c [2];
    logic        m_n [2];
    logic        m_v [2];
    logic        m_z [2];
    logic        m_ill;
    logic [15:0] m_ir;

    function automatic int wd(int k);
        return (k == 0) ? 16 : 8;
    endfunction

    function automatic logic [15:0] msk(int k);
        return (k == 0) ? 16'hFFFF : 16'h00FF;
    endfunction

    function automatic logic [15:0] topbit(int k);
        return (k == 0) ? 16'h8000 : 16'h0080;
    endfunction

    function automatic int to_int(logic [15:0] x, int k);
        if ((x & topbit(k)) != 0) return int'(x) - (1 << wd(k));
        return int'(x);
    endfunction

    function automatic logic [15:0] shf(logic [15:0] x, logic [1:0] sh, int k);
        case (sh)
            2'd1:    return (x << 1) & msk(k);
            2'd2:    return x >> 1;
            2'd3:    return (x >> 1) | (x & topbit(k));
            default: return x;
        endcase
    endfunction

    function automatic bit legal_op(logic [4:0] op);
        return op == 5'b11010 || op == 5'b11000 || op == 5'b10100 ||
               op == 5'b10101 || op == 5'b10110 || op == 5'b10111;
    endfunction

    task automatic set_flags(input int k, input logic [15:0] res, input logic ovf);
        m_c[k] = res;
        m_z[k] = (res == 16'd0);
        m_n[k] = (res & topbit(k)) != 0;
        m_v[k] = ovf;
    endtask

    task automatic model_step(input logic [15:0] word, input bit ld, output int lat);
        logic [4:0]  op;
        logic [15:0] a, b, res;
        int          t, lo, hi;
        if (ld) m_ir = word;
        op = m_ir[15:11];
        lat = 2;
        m_ill = !legal_op(op);
        for (int k = 0; k < 2; k++) begin
            a  = m_r[k][m_ir[10:8]];
            b  = shf(m_r[k][m_ir[2:0]], m_ir[4:3], k);
            hi = (1 << (wd(k) - 1)) - 1;
            lo = -(1 << (wd(k) - 1));
            case (op)
                5'b11010: begin
                    t = m_ir[7] ? int'(m_ir[7:0]) - 256 : int'(m_ir[7:0]);
                    m_r[k][m_ir[10:8]] = 16'(t) & msk(k);
                    lat = 3;
                end
                5'b11000: begin
                    m_c[k] = b;
                    m_r[k][m_ir[7:5]] = b;
                    lat = 5;
                end
                5'b10100: begin
                    t = to_int(a, k) + to_int(b, k);
                    res = 16'(t) & msk(k);
                    set_flags(k, res, t > hi || t < lo);
                    m_r[k][m_ir[7:5]] = res;
                    lat = 6;
                end
                5'b10101: begin
                    t = to_int(a, k) - to_int(b, k);
                    set_flags(k, 16'(t) & msk(k), t > hi || t < lo);
                    lat = 5;
                end
                5'b10110: begin
                    res = a & b;
                    set_flags(k, res, 1'b0);
                    m_r[k][m_ir[7:5]] = res;
                    lat = 6;
                end
                5'b10111: begin
                    res = ~b & msk(k);
                    set_flags(k, res, 1'b0);
                    m_r[k][m_ir[7:5]] = res;
                    lat = 5;
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_state(input string tag);
        check({tag, ":out16"}, 32'(out16), 32'(m_c[0]));
        check({tag, ":out8"},  32'(out8),  32'(m_c[1]));
        check({tag, ":nvz16"}, {29'd0, n16, v16, z16}, {29'd0, m_n[0], m_v[0], m_z[0]});
        check({tag, ":nvz8"},  {29'd0, n8, v8, z8},    {29'd0, m_n[1], m_v[1], m_z[1]});
        check({tag, ":ill"},   {30'd0, ill16, ill8},   {30'd0, m_ill, m_ill});
        check({tag, ":w8"},    32'(w8), 32'd1);
    endtask

    // Runs one instruction; noise drives s/load/in=FFFF during the DECODE cycle.
    task automatic issue(input logic [15:0] word, input bit ld, input bit noise);
        int lat;
        int exp_lat;
        string tg;
        tg = $sformatf("%04h", word);
        model_step(word, ld, exp_lat);
        check({tg, ":w_idle"}, 32'(w16), 32'd1);
        @(negedge clk);
        in = word; load = ld; s = 1'b1;
        @(posedge clk);
        #1;
        s = 1'b0; load = 1'b0; lat = 1;
        if (noise) begin
            in = 16'hFFFF; load = 1'b1; s = 1'b1;
        end
        do begin
            @(posedge clk);
            lat++;
            #1;
            s = 1'b0; load = 1'b0;
        end while (w16 !== 1'b1 && lat < 20);
        check({tg, ":latency"}, 32'(lat), 32'(exp_lat));
        compare_state(tg);
    endtask

    task automatic read_reg(input int r);
        logic [15:0] word;
        word = {5'b11000, 3'd0, 3'(r), 2'b00, 3'(r)};
        issue(word, 1'b1, 1'b0);
    endtask

    initial begin
        logic [4:0]  op;
        logic [4:0]  legal_ops [6];
        logic [15:0] word;
        int          pick;

        legal_ops = '{5'b11010, 5'b11000, 5'b10100, 5'b10101, 5'b10110, 5'b10111};

        reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst:w",   {30'd0, w16, w8}, 32'd3);
        check("rst:out", {out16, out8, 8'd0}, 32'd0);
        check("rst:nvz", {26'd0, n16, v16, z16, n8, v8, z8}, 32'd0);
        check("rst:ill", {30'd0, ill16, ill8}, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_c[k] = 16'd0; m_n[k] = 1'b0; m_v[k] = 1'b0; m_z[k] = 1'b0;
            for (int r = 0; r < 8; r++) m_r[k][r] = 16'd0;
        end
        m_ill = 1'b0; m_ir = 16'd0;

        // Instruction register resets to 0, an illegal opcode.
        issue(16'h1234, 1'b0, 1'b0);
        check("irrst:ill", 32'(ill16), 32'd1);

        for (int r = 0; r < 8; r++) issue({5'b11010, 3'(r), 8'($urandom)}, 1'b1, 1'b0);

        // 1: MOV R1,#1; MOV R2,#2; ADD R3,R1,R2 LSL1; MOV R0,#0x80
        issue(16'hD101, 1'b1, 1'b0);
        issue(16'hD202, 1'b1, 1'b0);
        issue(16'hA16A, 1'b1, 1'b0);
        check("t1:out", 32'(out16), 32'h5);
        check("t1:nvz", {29'd0, n16, v16, z16}, 32'd0);
        read_reg(3);
        check("t1:r3", 32'(out16), 32'h5);
        issue(16'hD080, 1'b1, 1'b0);
        read_reg(0);
        check("t1:r0_16", 32'(out16), 32'hFF80);
        check("t1:r0_8",  32'(out8),  32'h80);

        // 2: MOV R1,#2; MVN R2,R1 LSL1
        issue(16'hD102, 1'b1, 1'b0);
        issue(16'hB849, 1'b1, 1'b0);
        check("t2:out", 32'(out16), 32'hFFFB);
        check("t2:nvz", {29'd0, n16, v16, z16}, 32'b100);

        // 3: R1=1, CMP R1,R1
        issue(16'hD101, 1'b1, 1'b0);
        issue(16'hA901, 1'b1, 1'b0);
        check("t3:nvz", {29'd0, n16, v16, z16}, 32'b001);
        check("t3:out", 32'(out16), 32'h0);

        // 4: MOV R0,#127; MOV R1,#1; ADD R2,R0,R1
        issue(16'hD07F, 1'b1, 1'b0);
        issue(16'hD101, 1'b1, 1'b0);
        issue(16'hA041, 1'b1, 1'b0);
        check("t4:out8", 32'(out8), 32'h80);
        check("t4:nvz8", {29'd0, n8, v8, z8}, 32'b110);
        check("t4:out16", 32'(out16), 32'h80);

        // 5: illegal, then MOV R3,#5, then ADD with noise on s/load/in
        issue(16'hE000, 1'b1, 1'b0);
        check("t5:ill", 32'(ill16), 32'd1);
        issue(16'hD305, 1'b1, 1'b0);
        check("t5:ill_clr", 32'(ill16), 32'd0);
        issue(16'hA16A, 1'b1, 1'b1);
        issue(16'hA16A, 1'b0, 1'b0);

        // Random instruction stream
        for (int i = 0; i < 300; i++) begin
            pick = $urandom_range(0, 7);
            if (pick < 6) begin
                op = legal_ops[pick];
            end else begin
                do op = 5'($urandom); while (legal_op(op));
            end
            word = {op, 11'($urandom)};
            issue(word, $urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0);
        end
        for (int r = 0; r < 8; r++) read_reg(r);

        // 6: reset during EXEC of ADD R5,R1,R2 with R5 previously 7
        issue(16'hD507, 1'b1, 1'b0);
        @(negedge clk);
        in = 16'hA1A2; load = 1'b1; s = 1'b1;
        @(posedge clk);
        #1;
        s = 1'b0; load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t6:w",   {30'd0, w16, w8}, 32'd3);
        check("t6:out", {out16, out8, 8'd0}, 32'd0);
        check("t6:nvz", {26'd0, n16, v16, z16, n8, v8, z8}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            m_c[k] = 16'd0; m_n[k] = 1'b0; m_v[k] = 1'b0; m_z[k] = 1'b0;
        end
        for (int r = 0; r < 8; r++) m_r[1][r] = 16'd0;
        m_ill = 1'b0; m_ir = 16'd0;
        read_reg(5);
        check("t6:r5_16", 32'(out16), 32'd7);
        check("t6:r5_8",  32'(out8),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
